// File: rtl/cpu_dbg_pkg.sv
// Shared definitions for the CPU run controller: run-state encodings,
// the default debounce time and small state classification helpers.
package cpu_dbg_pkg;

  // 10 ms at 100 MHz
  localparam int DEB_CYCLES_DEFAULT = 1000000;

  typedef enum logic [2:0] {
    PAUSE = 3'd0,
    RUN   = 3'd1,
    DRAIN = 3'd2,
    STEP  = 3'd3,
    HALT  = 3'd4
  } run_state_e;

  // States in which the CPU may be clocked
  function automatic logic is_running(run_state_e s);
    return (s == RUN) || (s == DRAIN) || (s == STEP);
  endfunction

  // States in which the memory port may be lent to the debug viewer
  function automatic logic is_stopped(run_state_e s);
    return (s == PAUSE) || (s == HALT);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Step pushbutton conditioning: two-flop synchroniser, stability-count
// debouncer and a one-cycle pulse on each debounced rising edge.
module btn_debounce
  import cpu_dbg_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync_a;
  logic          sync_b;
  logic          level;
  logic [CW-1:0] cnt;

  // Synchronise, then accept a new level only after DEB_CYCLES stable samples
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
      level  <= 1'b0;
      cnt    <= '0;
      pulse  <= 1'b0;
    end else begin
      sync_a <= btn;
      sync_b <= sync_a;
      pulse  <= 1'b0;
      if (sync_b == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync_b;
        cnt   <= '0;
        pulse <= sync_b;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/cpu_run_ctrl.sv
// CPU run controller: decides when the CPU is clock-enabled (run, drain,
// single step, halt) and lends the shared memory port to the debug viewer
// while the CPU is stopped.
module cpu_run_ctrl
  import cpu_dbg_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT,
  parameter int RUN_DIV    = 1
) (
  input  logic        clk100m,
  input  logic        rst,
  input  logic        cont,
  input  logic        step,
  input  logic        mem,
  input  logic [7:0]  addr_t,
  input  logic        instr_done,
  input  logic        halt,
  input  logic [31:0] mem_rdata,
  output logic        cpu_ce,
  output logic        mem_sel,
  output logic [7:0]  dbg_addr,
  output logic [31:0] dbg_data,
  output logic        dbg_valid,
  output logic [2:0]  run_state
);

  localparam int PW = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(RUN_DIV - 1);

  run_state_e    state;
  run_state_e    state_next;
  logic [PW-1:0] presc;
  logic          step_pulse;
  logic          mem_sel_next;
  logic          addr_same;
  logic [1:0]    stab;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_step_btn (
    .clk   (clk100m),
    .rst   (rst),
    .btn   (step),
    .pulse (step_pulse)
  );

  // Next state, clock enable and memory ownership from the current state
  always_comb begin
    state_next = state;
    cpu_ce     = is_running(state) && (presc == PRESC_LAST);
    case (state)
      PAUSE: begin
        if (halt)            state_next = HALT;
        else if (cont)       state_next = RUN;
        else if (step_pulse) state_next = STEP;
      end
      RUN: begin
        if (cpu_ce && halt)  state_next = HALT;
        else if (!cont)      state_next = DRAIN;
      end
      DRAIN, STEP: begin
        if (cpu_ce && instr_done) state_next = halt ? HALT : PAUSE;
      end
      HALT:    state_next = HALT;
      default: state_next = PAUSE;
    endcase
    mem_sel_next = mem && is_stopped(state_next);
  end

  // State register
  always_ff @(posedge clk100m) begin
    if (!rst) state <= PAUSE;
    else      state <= state_next;
  end

  // Prescaler restarts on every state entry so the first enable is RUN_DIV cycles in
  always_ff @(posedge clk100m) begin
    if (!rst)                                         presc <= '0;
    else if (state_next != state || presc == PRESC_LAST) presc <= '0;
    else                                              presc <= presc + PW'(1);
  end

  assign addr_same = (addr_t == dbg_addr);

  // Debug viewer: present address, track its age, capture read data one cycle later
  always_ff @(posedge clk100m) begin
    if (!rst) begin
      mem_sel  <= 1'b0;
      dbg_addr <= '0;
      dbg_data <= '0;
      stab     <= 2'd0;
    end else begin
      mem_sel <= mem_sel_next;
      if (mem_sel_next) dbg_addr <= addr_t;
      if (!mem_sel_next || !mem_sel || !addr_same) stab <= 2'd0;
      else if (stab != 2'd2)                       stab <= stab + 2'd1;
      if (mem_sel && stab != 2'd0) dbg_data <= mem_rdata;
    end
  end

  assign dbg_valid = mem_sel && (stab == 2'd2) && addr_same;
  assign run_state = state;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Self-checking bench for cpu_run_ctrl with a short debounce time.
module tb_cpu_run_ctrl;
  import cpu_dbg_pkg::*;

  localparam int DEB = 4;
  localparam int DIV = 1;

  logic        clk100m = 1'b0;
  logic        rst, cont, step, mem, instr_done, halt;
  logic [7:0]  addr_t;
  logic [31:0] mem_rdata;
  logic        cpu_ce, mem_sel, dbg_valid;
  logic [7:0]  dbg_addr;
  logic [31:0] dbg_data;
  logic [2:0]  run_state;

  int errors = 0;
  int checks = 0;
  logic started = 1'b0;
  int step_entries = 0;
  logic [2:0] prev_rs = 3'd0;
  logic [31:0] mem_array [256];

  cpu_run_ctrl #(.DEB_CYCLES(DEB), .RUN_DIV(DIV)) dut (
    .clk100m    (clk100m),
    .rst        (rst),
    .cont       (cont),
    .step       (step),
    .mem        (mem),
    .addr_t     (addr_t),
    .instr_done (instr_done),
    .halt       (halt),
    .mem_rdata  (mem_rdata),
    .cpu_ce     (cpu_ce),
    .mem_sel    (mem_sel),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data),
    .dbg_valid  (dbg_valid),
    .run_state  (run_state)
  );

  always #5 clk100m = ~clk100m;

  // Shared memory with one cycle of read latency
  always @(posedge clk100m) mem_rdata <= mem_array[dbg_addr];

  // Behavioural model state
  run_state_e m_state;
  int         m_age;
  logic       m_s1, m_s2, m_level, m_pulse;
  logic [DEB-1:0] m_win;
  logic       m_sel;
  logic [7:0] m_addr;
  logic       m_sel_h0, m_sel_h1;
  logic [7:0] m_addr_h0, m_addr_h1;

  function automatic logic model_ce();
    return (m_state == RUN || m_state == DRAIN || m_state == STEP) && (m_age % DIV == DIV - 1);
  endfunction

  function automatic run_state_e model_next();
    run_state_e n;
    n = m_state;
    case (m_state)
      PAUSE: begin
        if (halt) n = HALT;
        else if (cont) n = RUN;
        else if (m_pulse) n = STEP;
      end
      RUN: begin
        if (model_ce() && halt) n = HALT;
        else if (!cont) n = DRAIN;
      end
      DRAIN, STEP: begin
        if (model_ce() && instr_done) n = halt ? HALT : PAUSE;
      end
      default: n = m_state;
    endcase
    return n;
  endfunction

  function automatic logic model_valid();
    return m_sel && m_sel_h0 && m_sel_h1 && (m_addr_h0 == m_addr) && (m_addr_h1 == m_addr) && (addr_t == m_addr);
  endfunction

  function automatic logic model_stopped(run_state_e s);
    return (s == PAUSE) || (s == HALT);
  endfunction

  always @(posedge clk100m) begin
    if (!rst) begin
      m_state  <= PAUSE;
      m_age    <= 0;
      m_s1     <= 1'b0;
      m_s2     <= 1'b0;
      m_level  <= 1'b0;
      m_pulse  <= 1'b0;
      m_win    <= '0;
      m_sel    <= 1'b0;
      m_addr   <= 8'h00;
      m_sel_h0 <= 1'b0;
      m_sel_h1 <= 1'b0;
      m_addr_h0 <= 8'h00;
      m_addr_h1 <= 8'h00;
    end else begin
      m_state  <= model_next();
      m_age    <= (model_next() != m_state) ? 0 : m_age + 1;
      m_sel    <= mem && model_stopped(model_next());
      if (mem && model_stopped(model_next())) m_addr <= addr_t;
      m_sel_h0  <= m_sel;
      m_sel_h1  <= m_sel_h0;
      m_addr_h0 <= m_addr;
      m_addr_h1 <= m_addr_h0;
      m_s1  <= step;
      m_s2  <= m_s1;
      m_win <= {m_win[DEB-2:0], m_s2};
      if ({m_win[DEB-2:0], m_s2} == {DEB{~m_level}}) begin
        m_level <= ~m_level;
        m_pulse <= ~m_level;
      end else begin
        m_pulse <= 1'b0;
      end
    end
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model
  always @(negedge clk100m) begin
    if (started) begin
      check_output("cpu_ce", 32'(cpu_ce), 32'(model_ce()));
      check_output("run_state", 32'(run_state), 32'(m_state));
      check_output("mem_sel", 32'(mem_sel), 32'(m_sel));
      check_output("dbg_addr", 32'(dbg_addr), 32'(m_addr));
      check_output("dbg_valid", 32'(dbg_valid), 32'(model_valid()));
      if (model_valid()) check_output("dbg_data", dbg_data, mem_array[m_addr]);
      check_output("ce_sel_excl", 32'(cpu_ce & mem_sel), 32'd0);
    end
  end

  // Count STEP entries seen on the outputs
  always @(negedge clk100m) begin
    prev_rs <= run_state;
    if (started && run_state == 3'd3 && prev_rs != 3'd3) step_entries <= step_entries + 1;
  end

  task automatic next_cycle();
    @(posedge clk100m);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem_array[i] = 32'h5A5A0000 + i;
    mem_array[2] = 32'hDEADBEEF;
    mem_array[3] = 32'hCAFEF00D;
    rst = 1'b0; cont = 1'b0; step = 1'b0; mem = 1'b0;
    addr_t = 8'h00; instr_done = 1'b0; halt = 1'b0;

    // Reset held for three edges with cont requested
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      started = 1'b1;
      cont = 1'b1;
      #1;
      check_output("rst_ce", 32'(cpu_ce), 32'd0);
      check_output("rst_state", 32'(run_state), 32'd0);
    end
    check_output("rst_dbg_data", dbg_data, 32'd0);
    check_output("rst_dbg_valid", 32'(dbg_valid), 32'd0);
    check_output("rst_mem_sel", 32'(mem_sel), 32'd0);
    rst = 1'b1;
    #1;
    check_output("rel_c1_ce", 32'(cpu_ce), 32'd0);
    next_cycle(); #1;
    check_output("rel_c2_ce", 32'(cpu_ce), 32'd1);
    check_output("rel_c2_state", 32'(run_state), 32'd1);
    next_cycle(); next_cycle();

    // Drain: cont falls, instruction completes five cycles later
    next_cycle();
    cont = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      next_cycle();
      if (i == 5) instr_done = 1'b1;
      #1;
      check_output("drain_ce", 32'(cpu_ce), 32'd1);
      check_output("drain_state", 32'(run_state), 32'd2);
    end
    next_cycle();
    instr_done = 1'b0;
    #1;
    check_output("drain_end_ce", 32'(cpu_ce), 32'd0);
    check_output("drain_end_state", 32'(run_state), 32'd0);

    // Memory view in PAUSE
    next_cycle();
    mem = 1'b1; addr_t = 8'h02;
    next_cycle(); #1;
    check_output("mv_c1_valid", 32'(dbg_valid), 32'd0);
    check_output("mv_c1_sel", 32'(mem_sel), 32'd1);
    next_cycle(); next_cycle(); #1;
    check_output("mv_addr", 32'(dbg_addr), 32'h02);
    check_output("mv_data", dbg_data, 32'hDEADBEEF);
    check_output("mv_valid", 32'(dbg_valid), 32'd1);
    addr_t = 8'h03;
    #1;
    check_output("mv_chg_valid", 32'(dbg_valid), 32'd0);
    repeat (3) next_cycle();
    #1;
    check_output("mv2_addr", 32'(dbg_addr), 32'h03);
    check_output("mv2_data", dbg_data, 32'hCAFEF00D);
    check_output("mv2_valid", 32'(dbg_valid), 32'd1);

    // Exclusivity: start running while the viewer is active
    cont = 1'b1;
    next_cycle(); #1;
    check_output("ex_sel", 32'(mem_sel), 32'd0);
    check_output("ex_ce", 32'(cpu_ce), 32'd1);
    check_output("ex_hold_data", dbg_data, 32'hCAFEF00D);
    check_output("ex_valid", 32'(dbg_valid), 32'd0);
    next_cycle(); cont = 1'b0;
    next_cycle(); instr_done = 1'b1;
    next_cycle(); instr_done = 1'b0; mem = 1'b0;
    #1;
    check_output("ex_back_state", 32'(run_state), 32'd0);
    check_output("ex_back_sel", 32'(mem_sel), 32'd1);
    next_cycle();

    // Bouncing step then a clean press
    for (int i = 0; i < 6; i++) begin
      next_cycle();
      step = (i % 2 == 0);
    end
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      step = 1'b1;
      if (i == 8) begin
        #1;
        check_output("step_state", 32'(run_state), 32'd3);
        check_output("step_ce", 32'(cpu_ce), 32'd1);
      end
      if (i == 9) instr_done = 1'b1;
    end
    next_cycle();
    instr_done = 1'b0;
    #1;
    check_output("step_end_state", 32'(run_state), 32'd0);
    check_output("step_end_ce", 32'(cpu_ce), 32'd0);
    repeat (4) next_cycle();
    step = 1'b0;
    repeat (8) next_cycle();
    check_output("step_entries", 32'(step_entries), 32'd1);

    // Halt from STEP, then nothing restarts it until reset
    for (int i = 0; i < 9; i++) begin
      next_cycle();
      step = 1'b1;
      if (i == 8) begin
        #1;
        check_output("halt_pre_state", 32'(run_state), 32'd3);
        halt = 1'b1; instr_done = 1'b1;
      end
    end
    next_cycle();
    halt = 1'b0; instr_done = 1'b0;
    #1;
    check_output("halt_state", 32'(run_state), 32'd4);
    check_output("halt_ce", 32'(cpu_ce), 32'd0);
    step = 1'b0;
    repeat (8) next_cycle();
    step = 1'b1;
    repeat (8) next_cycle();
    cont = 1'b1;
    repeat (3) next_cycle();
    cont = 1'b0;
    next_cycle(); #1;
    check_output("halt_stay_state", 32'(run_state), 32'd4);
    check_output("halt_stay_ce", 32'(cpu_ce), 32'd0);
    check_output("halt_step_entries", 32'(step_entries), 32'd2);
    step = 1'b0;

    // Reset leaves HALT, and reset abandons a run in progress
    rst = 1'b0;
    next_cycle(); #1;
    check_output("unhalt_state", 32'(run_state), 32'd0);
    rst = 1'b1;
    cont = 1'b1;
    next_cycle(); next_cycle(); #1;
    check_output("rerun_state", 32'(run_state), 32'd1);
    rst = 1'b0;
    next_cycle(); #1;
    check_output("midrun_rst_state", 32'(run_state), 32'd0);
    check_output("midrun_rst_ce", 32'(cpu_ce), 32'd0);
    rst = 1'b1;
    cont = 1'b0;
    repeat (4) next_cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
